crop_stream_source: RTL
=======================

// Module: crop_stream_source
// PURPOSE
//  Transmit end of the crop_plus_gaussian input interface. On ap_start it streams one raster-order
//  IN_ROWS x IN_COLS frame from a sync-read frame memory onto img_input_* (AXI-Stream, valid/ready).
//  It also sends one crop_Y1 beat and one crop_X1 beat per frame. Ports connect 1:1 to the crop block.
// PARAMETERS
//  PIXEL_BIT_WIDTH   16   pixel word width (ap_fixed<16,15>)
//  IN_ROWS           100  frame rows
//  IN_COLS           160  frame cols
//  IMG_ROW_BITWIDTH  10   width of crop_Y1
//  IMG_COL_BITWIDTH  10   width of crop_X1
//  ADDR_W  $clog2(IN_ROWS*IN_COLS) (14)  frame memory address width
// PORTS
//  ap_clk            in   1      single clock, all logic posedge
//  ap_rst            in   1      synchronous, active-high reset
//  ap_start          in   1      start one frame (sampled only in IDLE)
//  ap_ready          out  1      1-cycle pulse: start accepted, cfg latched
//  ap_done           out  1      1-cycle pulse: all three streams complete
//  ap_idle           out  1      high in IDLE
//  cfg_crop_y1       in   IMG_ROW_BITWIDTH  crop row origin, latched on start accept
//  cfg_crop_x1       in   IMG_COL_BITWIDTH  crop col origin, latched on start accept
//  mem_rd_en         out  1      frame-memory read strobe
//  mem_addr          out  ADDR_W pixel address, row*IN_COLS+col
//  mem_rdata         in   PIXEL_BIT_WIDTH  read data, valid 1 cycle after mem_rd_en
//  img_input_TDATA   out  PIXEL_BIT_WIDTH  pixel
//  img_input_TVALID  out  1
//  img_input_TREADY  in   1
//  crop_Y1_TDATA/TVALID out IMG_ROW_BITWIDTH/1;  crop_Y1_TREADY in 1
//  crop_X1_TDATA/TVALID out IMG_COL_BITWIDTH/1;  crop_X1_TREADY in 1
//  img_input_TLAST   out  1      only with CROP_SRC_TLAST_EN
// BEHAVIOUR
//  Reset: FSM=IDLE, ap_idle=1; ap_ready, ap_done, all TVALIDs and mem_rd_en =0.
//   Addr/beat counters =0; skid buffer emptied. Reset mid-frame aborts the frame, no ap_done.
//  FSM IDLE -> STREAM -> DONE -> IDLE.
//   IDLE: ap_start=1 -> latch cfg, pulse ap_ready next cycle, go STREAM.
//   STREAM: issue reads; exit when pixel count==IN_ROWS*IN_COLS and both crop beats are sent.
//   DONE: ap_done=1 for one cycle, then IDLE.
//  ap_start while not IDLE is ignored; it is not queued.
//  Crop beats: crop_Y1/X1_TVALID rise on the first STREAM cycle. Each holds until its own
//   TVALID&TREADY, then drops for the rest of the frame. TDATA is the latched cfg value.
//   The two crop beats are independent of each other and of the pixel stream.
//  Pixel stream: mem_rd_en = STREAM & addr<N & skid has room (counting in-flight reads).
//   addr increments on each read and saturates at N-1. No wrap; no read beyond N-1.
//  Latency: start accepted at edge k; read of addr 0 issued in cycle k+1; TVALID=1 in cycle k+2.
//   With TREADY held 1: one pixel/cycle; last beat in cycle k+N+1; ap_done at k+N+2 (crop beats done).
//  AXIS rules: TVALID never depends on TREADY. TDATA/TVALID stay stable while TVALID&!TREADY.
//   TVALID, once raised, does not drop until the handshake.
//  Skid: 2-entry FIFO absorbs the 1-cycle read latency. A TREADY 1->0 edge never loses a pixel.
//   Full: reads stall. Empty: TVALID=0. Simultaneous push and pop: occupancy unchanged.
//  Pixel count increments only on handshake. ap_done requires count==N exactly.
// CONFIGURATION
//  `ifdef CROP_SRC_TLAST_EN: img_input_TLAST=1 with the pixel whose count==N-1, else 0.
//   It is held with TDATA under backpressure.
//  Without the macro: port absent; end of frame is implied by the count.
// STRUCTURE
//  crop_pkg: pixel_t, row_t, col_t, addr_t typedefs; IN_ROWS/IN_COLS/FRAME_PIXELS defaults;
//   src_state_e enum {IDLE,STREAM,DONE}.
//  Sub-module axis_skid_fifo2 (2-deep valid/ready FIFO, params WIDTH[,+TLAST]) holds the pixel path.
//  FSM, address counter and crop-beat regs live in the top.
// TESTING
//  Flow: TREADY=1 always, Y1=37, X1=59, mem[i]=i -> beats 0..15999 in order.
//   First TVALID 2 cycles after start; ap_done 1 cycle after last beat.
//  Backpressure: TREADY random 50% -> 16000 beats, no dup/drop; TDATA stable while stalled.
//   mem_addr never exceeds 15999.
//  Crop stall: crop_X1_TREADY=0 until 200 cycles after last pixel -> ap_done waits for that beat.
//   X1 data =59, exactly one beat per crop stream.
//  Busy start: ap_start pulsed mid-frame with cfg_crop_y1=52 -> ignored; Y1 beat still 37.
//   No second ap_ready.
//  Abort: ap_rst=1 at beat 5000 -> next cycle all TVALID=0, ap_idle=1.
//   Restart streams from pixel 0.
//  CROP_SRC_TLAST_EN: TLAST high only on beat 15999, including when stalled.
//   Build without the macro compiles with no TLAST port.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop_plus_gaussian input source.
// The optional TLAST output is enabled with the CROP_SRC_TLAST_EN macro.
package crop_pkg;

    localparam int PIXEL_BIT_WIDTH  = 16;
    localparam int IN_ROWS          = 100;
    localparam int IN_COLS          = 160;
    localparam int IMG_ROW_BITWIDTH = 10;
    localparam int IMG_COL_BITWIDTH = 10;
    localparam int FRAME_PIXELS     = IN_ROWS * IN_COLS;
    localparam int ADDR_W           = $clog2(FRAME_PIXELS);

    typedef logic [PIXEL_BIT_WIDTH-1:0]  pixel_t;
    typedef logic [IMG_ROW_BITWIDTH-1:0] row_t;
    typedef logic [IMG_COL_BITWIDTH-1:0] col_t;
    typedef logic [ADDR_W-1:0]           addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } src_state_e;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry fall-through FIFO for the pixel path: an incoming word is presented
// immediately when empty and captured if the sink stalls, so output stays stable.
module axis_skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [1:0][WIDTH-1:0] mem_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q, cnt_d;
    logic                  empty, pop, store, drop;

    always_comb begin
        empty       = (cnt_q == 2'd0);
        out_valid_o = !empty || push_i;
        out_data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
        pop         = out_valid_o && out_ready_i;
        // A word popped on its arrival cycle bypasses storage entirely.
        store       = push_i && !(empty && pop);
        drop        = pop && !empty;
        cnt_d       = cnt_q + {1'b0, store} - {1'b0, drop};
    end

    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (store) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (drop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crop_stream_source.sv
// Streams one raster frame from a sync-read memory plus one crop_Y1 and one crop_X1 beat
// per ap_start. Define CROP_SRC_TLAST_EN to add img_input_TLAST on the final pixel.
module crop_stream_source #(
    parameter int PIXEL_BIT_WIDTH  = crop_pkg::PIXEL_BIT_WIDTH,
    parameter int IN_ROWS          = crop_pkg::IN_ROWS,
    parameter int IN_COLS          = crop_pkg::IN_COLS,
    parameter int IMG_ROW_BITWIDTH = crop_pkg::IMG_ROW_BITWIDTH,
    parameter int IMG_COL_BITWIDTH = crop_pkg::IMG_COL_BITWIDTH,
    parameter int ADDR_W           = $clog2(IN_ROWS * IN_COLS)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic                        ap_idle,
    input  logic [IMG_ROW_BITWIDTH-1:0] cfg_crop_y1,
    input  logic [IMG_COL_BITWIDTH-1:0] cfg_crop_x1,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [PIXEL_BIT_WIDTH-1:0]  mem_rdata,
    output logic [PIXEL_BIT_WIDTH-1:0]  img_input_TDATA,
    output logic                        img_input_TVALID,
    input  logic                        img_input_TREADY,
`ifdef CROP_SRC_TLAST_EN
    output logic                        img_input_TLAST,
`endif
    output logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    output logic                        crop_Y1_TVALID,
    input  logic                        crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    output logic                        crop_X1_TVALID,
    input  logic                        crop_X1_TREADY
);

    import crop_pkg::*;

    localparam int N     = IN_ROWS * IN_COLS;
    localparam int CNT_W = $clog2(N + 1);
`ifdef CROP_SRC_TLAST_EN
    localparam int FW    = PIXEL_BIT_WIDTH + 1;
`else
    localparam int FW    = PIXEL_BIT_WIDTH;
`endif

    src_state_e                  state_q, state_d;
    logic [IMG_ROW_BITWIDTH-1:0] y1_q, y1_d;
    logic [IMG_COL_BITWIDTH-1:0] x1_q, x1_d;
    logic                        y1_sent_q, y1_sent_d;
    logic                        x1_sent_q, x1_sent_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic                        rd_done_q, rd_done_d;
    logic                        rd_pend_q;
    logic [CNT_W-1:0]            pix_cnt_q, pix_cnt_d;
    logic                        ready_q;

    logic                        start_acc, rd_room, rd_en;
    logic                        y1_vld, x1_vld, y1_hs, x1_hs, pix_hs;
    logic [FW-1:0]               push_data, out_data;
    logic                        out_valid;
    logic [1:0]                  fifo_cnt;

`ifdef CROP_SRC_TLAST_EN
    logic rd_last_q;
    assign push_data       = {rd_last_q, mem_rdata};
    assign img_input_TLAST = out_data[FW-1];
`else
    assign push_data       = mem_rdata;
`endif

    always_comb begin
        start_acc = (state_q == IDLE) && ap_start;
        // Room is judged against stored words plus the read still in flight.
        rd_room   = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !rd_pend_q);
        rd_en     = (state_q == STREAM) && !rd_done_q && rd_room;
        y1_vld    = (state_q == STREAM) && !y1_sent_q;
        x1_vld    = (state_q == STREAM) && !x1_sent_q;
        y1_hs     = y1_vld && crop_Y1_TREADY;
        x1_hs     = x1_vld && crop_X1_TREADY;
        pix_hs    = out_valid && img_input_TREADY;

        state_d   = state_q;
        y1_d      = y1_q;
        x1_d      = x1_q;
        y1_sent_d = y1_sent_q | y1_hs;
        x1_sent_d = x1_sent_q | x1_hs;
        addr_d    = addr_q;
        rd_done_d = rd_done_q;
        pix_cnt_d = pix_cnt_q + CNT_W'(pix_hs);

        if (rd_en) begin
            if (addr_q == ADDR_W'(N - 1)) begin
                rd_done_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d   = STREAM;
                    y1_d      = cfg_crop_y1;
                    x1_d      = cfg_crop_x1;
                    y1_sent_d = 1'b0;
                    x1_sent_d = 1'b0;
                    addr_d    = '0;
                    rd_done_d = 1'b0;
                    pix_cnt_d = '0;
                end
            end
            STREAM: begin
                // Leave on the cycle the last handshake lands so ap_done follows it directly.
                if ((pix_cnt_d == CNT_W'(N)) && y1_sent_d && x1_sent_d) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            y1_q      <= '0;
            x1_q      <= '0;
            y1_sent_q <= 1'b0;
            x1_sent_q <= 1'b0;
            addr_q    <= '0;
            rd_done_q <= 1'b0;
            rd_pend_q <= 1'b0;
            pix_cnt_q <= '0;
            ready_q   <= 1'b0;
`ifdef CROP_SRC_TLAST_EN
            rd_last_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            y1_q      <= y1_d;
            x1_q      <= x1_d;
            y1_sent_q <= y1_sent_d;
            x1_sent_q <= x1_sent_d;
            addr_q    <= addr_d;
            rd_done_q <= rd_done_d;
            rd_pend_q <= rd_en;
            pix_cnt_q <= pix_cnt_d;
            ready_q   <= start_acc;
`ifdef CROP_SRC_TLAST_EN
            rd_last_q <= rd_en && (addr_q == ADDR_W'(N - 1));
`endif
        end
    end

    axis_skid_fifo2 #(
        .WIDTH (FW)
    ) u_skid (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .push_i      (rd_pend_q),
        .push_data_i (push_data),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (img_input_TREADY),
        .count_o     (fifo_cnt)
    );

    assign ap_ready         = ready_q;
    assign ap_done          = (state_q == DONE);
    assign ap_idle          = (state_q == IDLE);
    assign mem_rd_en        = rd_en;
    assign mem_addr         = addr_q;
    assign img_input_TVALID = out_valid;
    assign img_input_TDATA  = out_data[PIXEL_BIT_WIDTH-1:0];
    assign crop_Y1_TVALID   = y1_vld;
    assign crop_Y1_TDATA    = y1_q;
    assign crop_X1_TVALID   = x1_vld;
    assign crop_X1_TDATA    = x1_q;

endmodule
